seq_accum: RTL

- Parametrised, handshaked run-summing accumulator; next generation of the team's go_l-started summing block.
- Started by active-low go_l, it accepts a stream of unsigned words over valid/ready and sums them until a zero terminator word or a programmable element limit.
- It then pulses done with the final sum, element count and overflow status.
- Sits between a producer FIFO/stream source and control logic that consumes run totals.

---
 rtl/seq_accum_pkg.sv | 13 +
 rtl/seq_accum_add.sv | 32 +++
 rtl/seq_accum.sv | 118 +++++++++++
 3 files changed

// File: rtl/seq_accum_pkg.sv
// Shared types and default widths for the seq_accum run-summing accumulator.
package seq_accum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FIN
    } accum_state_t;

    localparam int DATA_W_DEF = 16;
    localparam int SUM_W_DEF  = 20;

endpackage

// File: rtl/seq_accum_add.sv
// Combinational adder for seq_accum: adds a zero-extended data word to the
// running sum and reports the carry out of SUM_W.
// Build option: define SEQ_ACCUM_SAT_EN to saturate at 2^SUM_W-1 on carry
// instead of wrapping modulo 2^SUM_W.
module seq_accum_add
    import seq_accum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SUM_W  = SUM_W_DEF
) (
    input  logic [SUM_W-1:0]  sum_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [SUM_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [SUM_W:0] raw_sum;

    // One extra bit captures the carry; the wrap/saturate choice is made here.
    always_comb begin
        raw_sum = {1'b0, sum_i} + {{(SUM_W + 1 - DATA_W){1'b0}}, data_i};
        carry_o = raw_sum[SUM_W];
`ifdef SEQ_ACCUM_SAT_EN
        // Once saturated, any further non-zero word carries again, so the
        // sum stays pinned at the maximum for the rest of the run.
        sum_o   = carry_o ? {SUM_W{1'b1}} : raw_sum[SUM_W-1:0];
`else
        sum_o   = raw_sum[SUM_W-1:0];
`endif
    end

endmodule

// File: rtl/seq_accum.sv
// seq_accum: go_l-started, valid/ready handshaked run accumulator. Sums
// unsigned words until a zero terminator or MAX_CNT non-zero words, then
// pulses done for one cycle with sum, count, ovf and by_limit.
// Build option: SEQ_ACCUM_SAT_EN selects saturating instead of wrapping sums.
module seq_accum
    import seq_accum_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int SUM_W   = SUM_W_DEF,
    parameter  int MAX_CNT = 255,
    localparam int CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_l,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              done,
    output logic [SUM_W-1:0]  sum,
    output logic [CNT_W-1:0]  count,
    output logic              ovf,
    output logic              by_limit
);

    accum_state_t     state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             by_limit_q, by_limit_d;

    logic [SUM_W-1:0] add_sum;
    logic             add_carry;
    logic [CNT_W-1:0] count_inc;
    logic             accept;

    seq_accum_add #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_add (
        .sum_i   (sum_q),
        .data_i  (in_data),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // Next-state and result update logic for the IDLE -> ACC -> FIN run.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        sum_d      = sum_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        by_limit_d = by_limit_q;
        accept     = in_valid && (state_q == ACC);
        count_inc  = count_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (!go_l) begin
                    state_d    = ACC;
                    sum_d      = '0;
                    count_d    = '0;
                    ovf_d      = 1'b0;
                    by_limit_d = 1'b0;
                end
            end
            ACC: begin
                if (accept) begin
                    if (in_data == '0) begin
                        state_d    = FIN;
                        by_limit_d = 1'b0;
                    end else begin
                        sum_d   = add_sum;
                        count_d = count_inc;
                        if (add_carry) begin
                            ovf_d = 1'b1;
                        end
                        if (count_inc == CNT_W'(MAX_CNT)) begin
                            state_d    = FIN;
                            by_limit_d = 1'b1;
                        end
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= IDLE;
            sum_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            by_limit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            by_limit_q <= by_limit_d;
        end
    end

    assign in_ready = (state_q == ACC);
    assign done     = (state_q == FIN);
    assign sum      = sum_q;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign by_limit = by_limit_q;

endmodule
